// File: rtl/regfile_2r2w.sv
// regfile_2r2w
//   Register file with DEPTH = 2**ADDR_W entries, two write ports for
//   dual-issue writeback and two registered, write-first read ports for decode.
//   Reads see the writes of the same clock edge, so no external forwarding is needed.
//
// Parameters
//   DATA_W     width of each register
//   ADDR_W     address width, DEPTH = 2**ADDR_W
//
// Ports
//   CLK        clock, all state updates on posedge
//   RST        asynchronous active-high clear of all entries and both read outputs
//   RE1/A1/RD1 read port 1: enable, address, registered data
//   RE2/A2/RD2 read port 2: enable, address, registered data
//   RegWrite1/A3/WD3  write port 1 (older instruction)
//   RegWrite2/A4/WD4  write port 2 (younger instruction, wins on address collision)
//
// Build option
//   REGFILE_ZERO_REG_EN  when defined, entry 0 is hardwired to zero; writes to
//                        address 0 are dropped and never bypassed to a read.

module regfile_2r2w #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              RE1,
   input  logic [ADDR_W-1:0] A1,
   output logic [DATA_W-1:0] RD1,
   input  logic              RE2,
   input  logic [ADDR_W-1:0] A2,
   output logic [DATA_W-1:0] RD2,
   input  logic              RegWrite1,
   input  logic [ADDR_W-1:0] A3,
   input  logic [DATA_W-1:0] WD3,
   input  logic              RegWrite2,
   input  logic [ADDR_W-1:0] A4,
   input  logic [DATA_W-1:0] WD4
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] rd1_q, rd1_d;
   logic [DATA_W-1:0] rd2_q, rd2_d;
   logic              we1_eff;
   logic              we2_eff;

`ifdef REGFILE_ZERO_REG_EN
   assign we1_eff = RegWrite1 && (A3 != '0);
   assign we2_eff = RegWrite2 && (A4 != '0);
`else
   assign we1_eff = RegWrite1;
   assign we2_eff = RegWrite2;
`endif

   // Next-state image of the array. Port 2 is applied last so it wins on a
   // collision; the same image feeds the read muxes, which gives the
   // write-first bypass order WD4 > WD3 > stored value for free.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (we1_eff && (A3 == ADDR_W'(i))) mem_d[i] = WD3;
         if (we2_eff && (A4 == ADDR_W'(i))) mem_d[i] = WD4;
      end
`ifdef REGFILE_ZERO_REG_EN
      mem_d[0] = '0;
`endif
   end

   // A deasserted read enable holds the previous output for pipeline stalls.
   always_comb begin
      rd1_d = rd1_q;
      rd2_d = rd2_q;
      if (RE1) rd1_d = mem_d[A1];
      if (RE2) rd2_d = mem_d[A2];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd1_q <= '0;
         rd2_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         rd1_q <= rd1_d;
         rd2_q <= rd2_d;
      end
   end

   assign RD1 = rd1_q;
   assign RD2 = rd2_q;

endmodule

// File: tb/tb_regfile_2r2w.sv
// Directed bench for regfile_2r2w (DATA_W=32, ADDR_W=5).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.

module tb_regfile_2r2w;

   logic        CLK;
   logic        RST;
   logic        RE1, RE2;
   logic [4:0]  A1, A2, A3, A4;
   logic [31:0] RD1, RD2, WD3, WD4;
   logic        RegWrite1, RegWrite2;

   int errors = 0;
   int checks = 0;

   regfile_2r2w #(.DATA_W(32), .ADDR_W(5)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .RE1       (RE1),
      .A1        (A1),
      .RD1       (RD1),
      .RE2       (RE2),
      .A2        (A2),
      .RD2       (RD2),
      .RegWrite1 (RegWrite1),
      .A3        (A3),
      .WD3       (WD3),
      .RegWrite2 (RegWrite2),
      .A4        (A4),
      .WD4       (WD4)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      RE1 = 1'b0; RE2 = 1'b0;
      RegWrite1 = 1'b0; RegWrite2 = 1'b0;
      A1 = '0; A2 = '0; A3 = '0; A4 = '0;
      WD3 = '0; WD4 = '0;
   endtask

   logic [31:0] zero_exp;

   initial begin
`ifdef REGFILE_ZERO_REG_EN
      zero_exp = 32'h0000_0000;
`else
      zero_exp = 32'hFFFF_FFFF;
`endif
      idle();
      RST = 1'b1;
      // writes and reads while in reset must be ignored
      RegWrite1 = 1'b1; A3 = 5'd3; WD3 = 32'h1111_1111;
      RE1 = 1'b1; A1 = 5'd3;
      tick();
      tick();
      chk("reset_rd1", RD1, 32'h0);
      chk("reset_rd2", RD2, 32'h0);
      idle();
      RST = 1'b0;
      RE1 = 1'b1; A1 = 5'd3;
      tick();
      chk("reset_ignored_write", RD1, 32'h0);

      // write with same-edge read bypass
      idle();
      RegWrite1 = 1'b1; A3 = 5'd5; WD3 = 32'hDEAD_BEEF;
      RE1 = 1'b1; A1 = 5'd5;
      tick();
      chk("bypass_wd3", RD1, 32'hDEAD_BEEF);

      // collision: port 2 wins, and the bypass follows it
      idle();
      RegWrite1 = 1'b1; A3 = 5'd7; WD3 = 32'h1;
      RegWrite2 = 1'b1; A4 = 5'd7; WD4 = 32'h2;
      RE2 = 1'b1; A2 = 5'd7;
      tick();
      chk("collision_bypass", RD2, 32'h2);
      idle();
      RE1 = 1'b1; A1 = 5'd7;
      tick();
      chk("collision_stored", RD1, 32'h2);

      // two writes to different entries, both bypassed; then A1==A2
      idle();
      RegWrite1 = 1'b1; A3 = 5'd10; WD3 = 32'hAAAA_0001;
      RegWrite2 = 1'b1; A4 = 5'd11; WD4 = 32'hBBBB_0002;
      RE1 = 1'b1; A1 = 5'd10;
      RE2 = 1'b1; A2 = 5'd11;
      tick();
      chk("dual_wr_rd1", RD1, 32'hAAAA_0001);
      chk("dual_wr_rd2", RD2, 32'hBBBB_0002);
      idle();
      RE1 = 1'b1; A1 = 5'd11;
      RE2 = 1'b1; A2 = 5'd11;
      tick();
      chk("same_addr_rd1", RD1, 32'hBBBB_0002);
      chk("same_addr_rd2", RD2, 32'hBBBB_0002);

      // stall: RE1=0 holds RD1 while the entry is rewritten
      idle();
      RegWrite1 = 1'b1; A3 = 5'd9; WD3 = 32'h1234;
      RE1 = 1'b1; A1 = 5'd9;
      tick();
      chk("stall_setup", RD1, 32'h1234);
      idle();
      A1 = 5'd9;
      RegWrite2 = 1'b1; A4 = 5'd9; WD4 = 32'h5678;
      tick();
      chk("stall_hold_wr_edge", RD1, 32'h1234);
      idle();
      A1 = 5'd9;
      tick();
      chk("stall_hold_idle", RD1, 32'h1234);
      RE1 = 1'b1;
      tick();
      chk("stall_release", RD1, 32'h5678);

      // address 0 behaviour, same-edge bypass and stored value, both ports
      idle();
      RegWrite1 = 1'b1; A3 = 5'd0; WD3 = 32'hFFFF_FFFF;
      RE1 = 1'b1; A1 = 5'd0;
      tick();
      chk("zero_bypass_p1", RD1, zero_exp);
      idle();
      RE1 = 1'b1; A1 = 5'd0;
      tick();
      chk("zero_stored_p1", RD1, zero_exp);
      idle();
      RegWrite2 = 1'b1; A4 = 5'd0; WD4 = 32'hFFFF_FFFF;
      RE2 = 1'b1; A2 = 5'd0;
      tick();
      chk("zero_bypass_p2", RD2, zero_exp);

      // async reset pulsed between edges: outputs clear without a clock edge
      idle();
      RE1 = 1'b1; A1 = 5'd9;
      RE2 = 1'b1; A2 = 5'd5;
      tick();
      chk("pre_rst_rd1", RD1, 32'h5678);
      chk("pre_rst_rd2", RD2, 32'hDEAD_BEEF);
      idle();
      RST = 1'b1;
      #1;
      chk("async_rst_rd1", RD1, 32'h0);
      chk("async_rst_rd2", RD2, 32'h0);
      RST = 1'b0;
      #1;
      for (int i = 0; i < 32; i++) begin
         RE1 = 1'b1; A1 = 5'(i);
         RE2 = 1'b1; A2 = 5'(31 - i);
         tick();
         chk($sformatf("rst_clear_%0d", i), RD1, 32'h0);
         chk($sformatf("rst_clear_rd2_%0d", 31 - i), RD2, 32'h0);
      end

      // sweep: entry i = i*3, even via port 1, odd via port 2
      for (int i = 0; i < 32; i++) begin
         idle();
         if (i % 2 == 0) begin
            RegWrite1 = 1'b1; A3 = 5'(i); WD3 = 32'(i * 3);
         end else begin
            RegWrite2 = 1'b1; A4 = 5'(i); WD4 = 32'(i * 3);
         end
         tick();
      end
      idle();
      for (int i = 0; i < 32; i++) begin
         RE1 = 1'b1; A1 = 5'(i);
         RE2 = 1'b1; A2 = 5'(31 - i);
         tick();
         chk($sformatf("sweep_rd1_%0d", i), RD1, 32'(i * 3));
         chk($sformatf("sweep_rd2_%0d", 31 - i), RD2, 32'((31 - i) * 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
